// File: rtl/seq_counter_gen.sv
// seq_counter_gen: table-driven wrap-around sequence counter.
// The state index steps forward or reverse by 1 or by STEP, wraps at both
// ends, and is mapped to an output value through a run-time-writable table.
// Optional macro SEQ_COUNTER_WRAP_FLAG_EN adds the oWrap boundary-crossing flag.
module seq_counter_gen #(
  parameter int DEPTH = 18,
  parameter int SW    = 5,
  parameter int VW    = 4,
  parameter int STEP  = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iEn,
  input  logic          iSkip,
  input  logic          iRev,
  input  logic          iLoad,
  input  logic [SW-1:0] iLoadState,
  input  logic          iWrEn,
  input  logic [SW-1:0] iWrAddr,
  input  logic [VW-1:0] iWrData,
  output logic [SW-1:0] oState,
  output logic [VW-1:0] oV
`ifdef SEQ_COUNTER_WRAP_FLAG_EN
  ,
  output logic          oWrap
`endif
);

  // One extra bit so that state + DEPTH never overflows before the modulo.
  localparam logic [SW:0] DEPTH_W = (SW+1)'(DEPTH);
  localparam logic [SW:0] STEP_W  = (SW+1)'(STEP);
  localparam logic [SW:0] ONE_W   = (SW+1)'(1);

  // Sequence table; deliberately not reset so that contents survive iRst.
  logic [VW-1:0] seqTab [DEPTH];

  logic          wrOk;
  logic          loadOk;
  logic          stepping;
  logic [SW:0]   incW;
  logic [SW:0]   fwdSum;
  logic [SW:0]   revSum;
  logic [SW:0]   fwdMod;
  logic [SW:0]   revMod;
  logic [SW-1:0] stepNxt;
  logic [SW-1:0] stateNxt;
  logic [VW-1:0] vNxt;
  logic          crossed;
  logic [1:0]    unusedTopBits;

  // Range checks for writes and loads, done at SW+1 bits to keep widths matched.
  always_comb begin
    wrOk   = iWrEn && ({1'b0, iWrAddr} < DEPTH_W);
    loadOk = {1'b0, iLoadState} < DEPTH_W;
  end

  // Stride arithmetic: both directions computed, then reduced modulo DEPTH.
  // Operands are below DEPTH, so a single conditional subtract suffices.
  always_comb begin
    incW   = iSkip ? STEP_W : ONE_W;
    fwdSum = {1'b0, oState} + incW;
    revSum = {1'b0, oState} + DEPTH_W - incW;
    fwdMod = (fwdSum >= DEPTH_W) ? (fwdSum - DEPTH_W) : fwdSum;
    revMod = (revSum >= DEPTH_W) ? (revSum - DEPTH_W) : revSum;
    stepNxt = iRev ? revMod[SW-1:0] : fwdMod[SW-1:0];
    // The top bit is always zero after reduction.
    unusedTopBits = {fwdMod[SW], revMod[SW]};
  end

  // Next-state resolution: reset > load > step > hold.
  always_comb begin
    stateNxt = oState;
    stepping = 1'b0;
    if (iRst) begin
      stateNxt = '0;
    end else if (iLoad) begin
      if (loadOk) stateNxt = iLoadState;
    end else if (iEn) begin
      stateNxt = stepNxt;
      stepping = 1'b1;
    end
  end

  // Output value lookup with write-first bypass when the write hits the next entry.
  always_comb begin
    vNxt = seqTab[stateNxt];
    if (wrOk && (iWrAddr == stateNxt)) vNxt = iWrData;
  end

  // Boundary crossing: forward step landed below, or reverse step landed above.
  always_comb begin
    crossed = 1'b0;
    if (stepping) crossed = iRev ? (stepNxt > oState) : (stepNxt < oState);
  end

  // Table write port; accepted in every mode, including reset.
  always_ff @(posedge iClk) begin
    if (wrOk) seqTab[iWrAddr] <= iWrData;
  end

  // State and aligned value registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oState <= '0;
    end else begin
      oState <= stateNxt;
    end
    // In reset stateNxt is 0, so vNxt is the (write-first) entry 0.
    oV <= vNxt;
  end

`ifdef SEQ_COUNTER_WRAP_FLAG_EN
  // Single-cycle wrap flag aligned with the stepped oState.
  always_ff @(posedge iClk) begin
    if (iRst) oWrap <= 1'b0;
    else      oWrap <= crossed;
  end
`else
  logic unusedCrossed;
  assign unusedCrossed = crossed;
`endif

endmodule
